// File: rtl/mp3_display_overlay.sv
// MP3 player UI pixel generator: debounced buttons drive track/volume state, colour is registered one clk after x/y.
// Button-to-state latency is 2 sync + DEBOUNCE_CYCLES + 1 edge + 1 state cycles; no backpressure, colour is produced every cycle.
module mp3_display_overlay #(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int NUM_TRACKS      = 4,
    parameter int VOL_MAX         = 15,
    parameter int VOL_INIT        = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] i_x,
    input  logic signed [15:0] i_y,
    input  logic               i_next,
    input  logic               i_pre,
    input  logic               i_vol_plus,
    input  logic               i_vol_dec,
    output logic [7:0]         o_red,
    output logic [7:0]         o_green,
    output logic [7:0]         o_blue
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(NUM_TRACKS);
    localparam int VW = $clog2(VOL_MAX + 1);

    localparam logic signed [15:0] H_LIM = 16'(H_RES);
    localparam logic signed [15:0] V_LIM = 16'(V_RES);

    localparam logic [23:0] C_BLACK  = 24'h000000;
    localparam logic [23:0] C_YELLOW = 24'hFFC000;
    localparam logic [23:0] C_GREY   = 24'h606060;
    localparam logic [23:0] C_GREEN  = 24'h00FF00;
    localparam logic [23:0] C_DGREY  = 24'h303030;
    localparam logic [23:0] C_BG     = 24'h101040;

    // Bit order: 0 next, 1 pre, 2 vol_plus, 3 vol_dec
    logic [3:0]    btn_raw;
    logic [3:0]    sync0_q, sync1_q;
    logic [3:0]    db_q, db_d, db_prev_q, press_q;
    logic [3:0]    armed_q, armed_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [TW-1:0] trk_q, trk_d;
    logic [VW-1:0] vol_q, vol_d;
    logic [23:0]   rgb_q, rgb_d;

    assign btn_raw = {i_vol_dec, i_vol_plus, i_pre, i_next};

    // An unarmed button (after reset) must first be seen stably low, so a press held through reset is dropped.
    always_comb begin
        db_d    = db_q;
        armed_d = armed_q;
        for (int b = 0; b < 4; b++) begin
            cnt_d[b] = cnt_q[b];
            if (!armed_q[b]) begin
                if (sync1_q[b]) begin
                    cnt_d[b] = '0;
                end else if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_d[b]   = '0;
                    armed_d[b] = 1'b1;
                end else begin
                    cnt_d[b] = cnt_q[b] + CW'(1);
                end
            end else if (sync1_q[b] == db_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_d[b] = '0;
                db_d[b]  = sync1_q[b];
            end else begin
                cnt_d[b] = cnt_q[b] + CW'(1);
            end
        end
    end

    always_comb begin
        trk_d = trk_q;
        case ({press_q[1], press_q[0]})
            2'b01:   trk_d = (trk_q == TW'(NUM_TRACKS - 1)) ? '0 : trk_q + TW'(1);
            2'b10:   trk_d = (trk_q == '0) ? TW'(NUM_TRACKS - 1) : trk_q - TW'(1);
            default: trk_d = trk_q;
        endcase
        vol_d = vol_q;
        case ({press_q[3], press_q[2]})
            2'b01:   vol_d = (vol_q == VW'(VOL_MAX)) ? vol_q : vol_q + VW'(1);
            2'b10:   vol_d = (vol_q == '0) ? vol_q : vol_q - VW'(1);
            default: vol_d = vol_q;
        endcase
    end

    logic               hit;
    logic signed [15:0] lo, hi;
    always_comb begin
        rgb_d = C_BG;
        hit   = 1'b0;
        lo    = '0;
        hi    = '0;
        if (i_x < 0 || i_y < 0 || i_x >= H_LIM || i_y >= V_LIM) begin
            rgb_d = C_BLACK;
        end else begin
            for (int k = 0; k < NUM_TRACKS; k++) begin
                lo = 16'(64 + 96 * k);
                hi = 16'(127 + 96 * k);
                if (!hit && i_y >= 16'sd96 && i_y <= 16'sd159 && i_x >= lo && i_x <= hi) begin
                    hit   = 1'b1;
                    rgb_d = (TW'(k) == trk_q) ? C_YELLOW : C_GREY;
                end
            end
            for (int k = 0; k <= VOL_MAX; k++) begin
                lo = 16'(64 + 32 * k);
                hi = 16'(87 + 32 * k);
                if (!hit && i_y >= 16'sd320 && i_y <= 16'sd351 && i_x >= lo && i_x <= hi) begin
                    hit   = 1'b1;
                    rgb_d = (VW'(k) < vol_q) ? C_GREEN : C_DGREY;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q   <= '0;
            sync1_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            press_q   <= '0;
            armed_q   <= '0;
            for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
            trk_q     <= '0;
            vol_q     <= VW'(VOL_INIT);
            rgb_q     <= '0;
        end else begin
            sync0_q   <= btn_raw;
            sync1_q   <= sync0_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            press_q   <= db_q & ~db_prev_q;
            armed_q   <= armed_d;
            for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
            trk_q     <= trk_d;
            vol_q     <= vol_d;
            rgb_q     <= rgb_d;
        end
    end

    assign o_red   = rgb_q[23:16];
    assign o_green = rgb_q[15:8];
    assign o_blue  = rgb_q[7:0];
endmodule

// File: tb/tb_mp3_display_overlay.sv
// Randomized bench for mp3_display_overlay against a region/arith reference model of the UI state.
module tb_mp3_display_overlay;
    localparam int NT   = 4;
    localparam int VMAX = 15;
    localparam int VINI = 8;
    localparam int DB   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] i_x, i_y;
    logic [3:0]         btn;
    logic [7:0]         o_red, o_green, o_blue;

    int n_checks = 0;
    int n_fail   = 0;
    int m_trk, m_vol;

    always #5 clk = ~clk;

    mp3_display_overlay #(
        .H_RES(640), .V_RES(480), .NUM_TRACKS(NT), .VOL_MAX(VMAX),
        .VOL_INIT(VINI), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_x(i_x), .i_y(i_y),
        .i_next(btn[0]), .i_pre(btn[1]), .i_vol_plus(btn[2]), .i_vol_dec(btn[3]),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_pix(input int x, input int y);
        int k;
        if (x < 0 || y < 0 || x >= 640 || y >= 480) return 24'h000000;
        if (y >= 96 && y <= 159 && x >= 64) begin
            k = (x - 64) / 96;
            if (k < NT && (x - 64) % 96 < 64) return (k == m_trk) ? 24'hFFC000 : 24'h606060;
        end
        if (y >= 320 && y <= 351 && x >= 64) begin
            k = (x - 64) / 32;
            if (k <= VMAX && (x - 64) % 32 < 24) return (k < m_vol) ? 24'h00FF00 : 24'h303030;
        end
        return 24'h101040;
    endfunction

    task automatic pix(input string tag, input int x, input int y);
        @(negedge clk);
        i_x = 16'(x);
        i_y = 16'(y);
        @(posedge clk);
        @(negedge clk);
        chk(tag, {8'h0, o_red, o_green, o_blue}, {8'h0, ref_pix(x, y)});
    endtask

    // Holds of at least DB cycles count as presses; shorter ones are glitches.
    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clk);
        btn = mask;
        repeat (hold) @(negedge clk);
        btn = 4'b0;
        repeat (20) @(negedge clk);
        if (hold >= DB) begin
            if (mask[0] && !mask[1]) m_trk = (m_trk + 1) % NT;
            if (mask[1] && !mask[0]) m_trk = (m_trk + NT - 1) % NT;
            if (mask[2] && !mask[3]) m_vol = (m_vol < VMAX) ? m_vol + 1 : VMAX;
            if (mask[3] && !mask[2]) m_vol = (m_vol > 0) ? m_vol - 1 : 0;
        end
    endtask

    initial begin
        int x, y, hold;
        logic [3:0] mask;
        btn   = 4'b0;
        i_x   = 16'sd70;
        i_y   = 16'sd100;
        rst_n = 1'b0;
        m_trk = 0;
        m_vol = VINI;
        repeat (3) @(posedge clk);
        #1 chk("reset_rgb", {8'h0, o_red, o_green, o_blue}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        pix("rst_trk0_box", 70, 100);
        pix("rst_trk1_box", 160, 100);

        press(4'b0010, 10);
        pix("pre_wrap_box3", 64 + 96 * 3 + 5, 100);
        pix("pre_wrap_box0", 70, 100);
        press(4'b0001, 10);
        pix("next_wrap_box0", 70, 100);
        for (int i = 0; i < NT; i++) press(4'b0001, 10);
        pix("next_full_cycle", 70, 100);

        pix("vol_seg7", 64 + 32 * 7 + 2, 330);
        pix("vol_seg8", 64 + 32 * 8 + 2, 330);
        for (int i = 0; i < 20; i++) press(4'b0100, 8);
        pix("vol_sat_seg15", 64 + 32 * 15 + 2, 330);
        for (int i = 0; i < 20; i++) press(4'b1000, 8);
        pix("vol_sat_seg0", 66, 330);

        press(4'b0001, 2);
        pix("glitch_box0", 70, 100);
        press(4'b0001, 100);
        pix("long_hold_box1", 160, 100);
        pix("long_hold_box0", 70, 100);

        pix("region_xneg", -1, 100);
        pix("region_xmax", 640, 100);
        pix("region_ymax", 100, 480);
        pix("region_bg_a", 10, 10);
        pix("region_bg_b", 100, 200);
        press(4'b0010, 10);
        pix("edge_in", 127, 159);
        pix("edge_out", 128, 159);

        press(4'b0011, 10);
        pix("simul_trk", 70, 100);
        press(4'b1100, 10);
        pix("simul_vol", 64 + 32 * 7 + 2, 330);

        // Reset while a press is still held: the press is abandoned until released.
        @(negedge clk);
        btn = 4'b0001;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("midpress_rst_rgb", {8'h0, o_red, o_green, o_blue}, 32'h0);
        m_trk = 0;
        m_vol = VINI;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        btn = 4'b0;
        repeat (20) @(negedge clk);
        pix("midpress_box0", 70, 100);
        pix("midpress_vol8", 64 + 32 * 8 + 2, 330);
        press(4'b0001, 10);
        pix("after_rst_press", 160, 100);

        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(1, 15));
            hold = ($urandom_range(0, 4) == 0) ? 2 : int'($urandom_range(8, 30));
            press(mask, hold);
            pix("rnd_track", int'($urandom_range(40, 470)), int'($urandom_range(90, 165)));
            pix("rnd_vol", int'($urandom_range(40, 600)), int'($urandom_range(315, 356)));
            x = int'($urandom_range(0, 720)) - 40;
            y = int'($urandom_range(0, 540)) - 30;
            pix("rnd_any", x, y);
        end
        for (int k = 0; k < NT; k++) pix("final_box", 64 + 96 * k + 30, 128);
        for (int k = 0; k <= VMAX; k++) pix("final_seg", 64 + 32 * k + 12, 335);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
